// File: rtl/inv_mix_columns_seq_if.sv
// rtl/inv_mix_columns_seq_if.sv - state in/out handshake bundle for inv_mix_columns_seq
interface inv_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inv_mix_columns_seq_if.slave  bus
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $fatal(1, "inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Step wraps to 0 for COLS_PER_CYCLE=4, so a single pass both starts and ends at cnt 0.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);
  localparam logic [2:0] COLS_W   = 3'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d, work_upd;
  logic         in_ready, out_valid;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

  // Columns whose offset from cnt falls inside the current group are replaced in place.
  always_comb begin
    logic [1:0] rel;
    work_upd = work_q;
    for (int c = 0; c < 4; c++) begin
      rel = 2'(c) - cnt_q;
      if ({1'b0, rel} < COLS_W) begin
        work_upd[127-32*c -: 32] = inv_mix_col(work_q[127-32*c -: 32]);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          work_d  = bus.state_in;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d = work_upd;
        cnt_d  = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.state_out = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - directed self-checking bench for inv_mix_columns_seq
module tb_inv_mix_columns_seq;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] state_in;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  inv_mix_columns_seq_if if1 ();
  inv_mix_columns_seq_if if2 ();
  inv_mix_columns_seq_if if4 ();

  assign if1.in_valid = in_valid;
  assign if1.state_in = state_in;
  assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;
  assign if2.state_in = state_in;
  assign if2.out_ready = out_ready;
  assign if4.in_valid = in_valid;
  assign if4.state_in = state_in;
  assign if4.out_ready = out_ready;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] o = '0;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(base[(k - r + 4) % 4], s[127-32*c-8*k -: 8]);
        end
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic wait_valid1(output int n);
    n = 0;
    while (!if1.out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int           lat;
    int           prev_acc;
    int           acc_cyc;
    logic [127:0] rnd;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
    tick(); tick();
    check_eq("rst_out_valid", if1.out_valid, 1'b0);
    check_eq("rst_state_out", if1.state_out, '0);
    check_eq("rst_in_ready", if1.in_ready, 1'b1);
    rst_n = 1'b1;

    // Round trip: all three widths accept on the same edge.
    in_valid = 1'b1; state_in = V2;
    tick();
    in_valid = 1'b0;
    check_eq("rt_busy_in_ready", if1.in_ready, 1'b0);
    tick();
    check_eq("rt4_valid", if4.out_valid, 1'b1);
    check_eq("rt4_state", if4.state_out, E2);
    check_eq("rt2_early", if2.out_valid, 1'b0);
    tick();
    check_eq("rt2_valid", if2.out_valid, 1'b1);
    check_eq("rt2_state", if2.state_out, E2);
    tick();
    check_eq("rt1_early", if1.out_valid, 1'b0);
    tick();
    check_eq("rt1_valid", if1.out_valid, 1'b1);
    check_eq("rt1_state", if1.state_out, E2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("rt_drain_valid", if1.out_valid, 1'b0);
    check_eq("rt_drain_ready", if1.in_ready, 1'b1);

    // Single-column vector with in_valid toggled while busy.
    in_valid = 1'b1; state_in = V1;
    tick();
    check_eq("v1_in_ready", if1.in_ready, 1'b0);
    lat = 0;
    while (!if1.out_valid && lat < 20) begin
      in_valid = ~lat[0];
      state_in = V2;
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check_eq("v1_latency", lat, 4);
    check_eq("v1_state", if1.state_out, E1);

    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_valid", if1.out_valid, 1'b1);
      check_eq("bp_state", if1.state_out, E1);
      check_eq("bp_in_ready", if1.in_ready, 1'b0);
    end
    out_ready = 1'b1; in_valid = 1'b1; state_in = V2;
    tick();
    out_ready = 1'b0;
    check_eq("bp_release_valid", if1.out_valid, 1'b0);
    check_eq("bp_release_ready", if1.in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_eq("second_accept", if1.in_ready, 1'b0);
    wait_valid1(lat);
    check_eq("second_latency", lat, 4);
    check_eq("second_state", if1.state_out, E2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset with cnt = 2.
    in_valid = 1'b1; state_in = V1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_valid", if1.out_valid, 1'b0);
    check_eq("mid_rst_state", if1.state_out, '0);
    rst_n = 1'b1;
    tick();
    check_eq("mid_rst_in_ready", if1.in_ready, 1'b1);
    in_valid = 1'b1; state_in = V2;
    tick();
    in_valid = 1'b0;
    wait_valid1(lat);
    check_eq("post_rst_latency", lat, 4);
    check_eq("post_rst_state", if1.state_out, E2);
    out_ready = 1'b1;
    tick();

    // Back-to-back with both handshakes held high.
    in_valid = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      state_in = rnd;
      lat = 0;
      while (!if1.in_ready && lat < 20) begin
        tick();
        lat++;
      end
      tick();
      acc_cyc = cyc;
      if (i > 0) check_eq("b2b_spacing", acc_cyc - prev_acc, 6);
      prev_acc = acc_cyc;
      wait_valid1(lat);
      check_eq("b2b_latency", lat, 4);
      check_eq("b2b_state", if1.state_out, ref_model(rnd));
    end
    in_valid = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
